// File: rtl/sid_envelope_pkg.sv
// Shared types and constants for the SID ADSR envelope generator:
// register slice layout, envelope states and the rate period table.
package sid_envelope_pkg;

  typedef logic [7:0]  reg8_t;
  typedef logic [14:0] reg15_t;
  typedef logic [4:0]  reg5_t;

  typedef enum logic [1:0] {
    ATTACK        = 2'd0,
    DECAY_SUSTAIN = 2'd1,
    RELEASE       = 2'd2
  } env_state_e;

  typedef struct packed {
    logic       gate;
    logic [3:0] attack;
    logic [3:0] decay;
    logic [3:0] sustain;
    logic [3:0] release_;
  } envelope_reg_t;

  // Ticks per rate step, indexed by the 4-bit attack/decay/release value.
  localparam reg15_t RATE_PERIOD [16] = '{
    15'd9,    15'd32,   15'd63,   15'd95,
    15'd149,  15'd220,  15'd267,  15'd313,
    15'd392,  15'd977,  15'd1954, 15'd3126,
    15'd3907, 15'd11720, 15'd19532, 15'd31251
  };

  // Piecewise-exponential decay: the exponential divider only changes
  // when the level lands exactly on one of these breakpoints.
  function automatic reg5_t exp_period_for(input reg8_t level, input reg5_t current);
    reg5_t result;
    result = current;
    case (level)
      8'hFF: result = 5'd1;
      8'h5D: result = 5'd2;
      8'h36: result = 5'd4;
      8'h1A: result = 5'd8;
      8'h0E: result = 5'd16;
      8'h06: result = 5'd30;
      8'h00: result = 5'd1;
      default: result = current;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sid_envelope_if.sv
// Register slice, tick strobe and envelope readback of one SID voice's
// envelope generator, grouped for connection between core and generator.
interface sid_envelope_if;

  logic                                tick;
  sid_envelope_pkg::envelope_reg_t     regs;
  sid_envelope_pkg::reg8_t             env;
  sid_envelope_pkg::env_state_e        state;

  modport master (
    output tick,
    output regs,
    input  env,
    input  state
  );

  modport slave (
    input  tick,
    input  regs,
    output env,
    output state
  );

endinterface

// File: rtl/sid_envelope_rate.sv
// Rate counter and period lookup producing one rate_step per period ticks.
// SID_ENV_ADSR_BUG_EN selects the original chip's equality-only compare.
module sid_envelope_rate
  import sid_envelope_pkg::*;
#(
  parameter int RATE_W = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] rate_idx,
  output logic       rate_step
);

  logic [RATE_W-1:0] rate_cnt_reg;
  logic [RATE_W-1:0] rate_cnt_next;
  logic [RATE_W-1:0] period_m1;
  logic              hit;

  always_comb begin
    period_m1 = RATE_W'(RATE_PERIOD[rate_idx]) - RATE_W'(1);
`ifdef SID_ENV_ADSR_BUG_EN
    // Lowering the period below the running count misses the compare and
    // the counter must wrap all the way around before the next step.
    hit = (rate_cnt_reg == period_m1);
`else
    hit = (rate_cnt_reg >= period_m1);
`endif
    rate_step     = tick & hit;
    rate_cnt_next = rate_cnt_reg;
    if (tick) begin
      rate_cnt_next = hit ? '0 : rate_cnt_reg + RATE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_cnt_reg <= '0;
    end else begin
      rate_cnt_reg <= rate_cnt_next;
    end
  end

endmodule

// File: rtl/sid_envelope.sv
// One voice's ADSR envelope generator: gate-driven state machine plus the
// exponential decay divider. SID_ENV_ADSR_BUG_EN alters the rate compare.
module sid_envelope
  import sid_envelope_pkg::*;
#(
  parameter int RATE_W = 15,
  parameter int EXP_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  sid_envelope_if.slave  bus
);

  env_state_e        state_reg, state_next;
  reg8_t             env_reg, env_next;
  logic [EXP_W-1:0]  exp_cnt_reg, exp_cnt_next, exp_cnt_inc;
  logic [EXP_W-1:0]  exp_period_reg, exp_period_next;
  logic              hold_zero_reg, hold_zero_next;
  logic              gate_q_reg, gate_q_next;
  logic [3:0]        rate_idx;
  logic              rate_step;
  logic              env_step;
  reg8_t             sustain_level;

  always_comb begin
    case (state_reg)
      ATTACK:        rate_idx = bus.regs.attack;
      DECAY_SUSTAIN: rate_idx = bus.regs.decay;
      default:       rate_idx = bus.regs.release_;
    endcase
  end

  sid_envelope_rate #(
    .RATE_W (RATE_W)
  ) u_rate (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (bus.tick),
    .rate_idx  (rate_idx),
    .rate_step (rate_step)
  );

  assign sustain_level = {bus.regs.sustain, bus.regs.sustain};
  assign exp_cnt_inc   = exp_cnt_reg + EXP_W'(1);

  always_comb begin
    state_next      = state_reg;
    env_next        = env_reg;
    exp_cnt_next    = exp_cnt_reg;
    exp_period_next = exp_period_reg;
    hold_zero_next  = hold_zero_reg;
    gate_q_next     = gate_q_reg;
    env_step        = 1'b0;

    if (bus.tick) begin
      gate_q_next = bus.regs.gate;

      // The step uses the state held before any gate edge in this tick.
      if (rate_step) begin
        if (state_reg == ATTACK) begin
          exp_cnt_next = '0;
          if (env_reg != 8'hFF) begin
            env_next = env_reg + 8'd1;
          end
          if (env_reg >= 8'hFE) begin
            state_next = DECAY_SUSTAIN;
          end
        end else if (exp_cnt_inc == exp_period_reg) begin
          exp_cnt_next = '0;
          env_step     = 1'b1;
        end else begin
          exp_cnt_next = exp_cnt_inc;
        end
      end

      if (env_step && (env_reg != 8'h00)) begin
        if ((state_reg == DECAY_SUSTAIN) && (env_reg != sustain_level)) begin
          env_next = env_reg - 8'd1;
        end else if ((state_reg == RELEASE) && !hold_zero_reg) begin
          env_next = env_reg - 8'd1;
        end
      end

      if (env_next != env_reg) begin
        exp_period_next = EXP_W'(exp_period_for(env_next, 5'(exp_period_reg)));
        if (env_next == 8'h00) begin
          hold_zero_next = 1'b1;
        end
      end

      if (bus.regs.gate && !gate_q_reg) begin
        state_next     = ATTACK;
        hold_zero_next = 1'b0;
      end else if (!bus.regs.gate && gate_q_reg) begin
        state_next = RELEASE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= RELEASE;
      env_reg        <= '0;
      exp_cnt_reg    <= '0;
      exp_period_reg <= EXP_W'(1);
      hold_zero_reg  <= 1'b1;
      gate_q_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      env_reg        <= env_next;
      exp_cnt_reg    <= exp_cnt_next;
      exp_period_reg <= exp_period_next;
      hold_zero_reg  <= hold_zero_next;
      gate_q_reg     <= gate_q_next;
    end
  end

  assign bus.env   = env_reg;
  assign bus.state = state_reg;

endmodule

// File: tb/tb_sid_envelope.sv
// Directed and randomized bench for sid_envelope against a behavioural
// ADSR model evaluated once per clock edge.
module tb_sid_envelope;
  import sid_envelope_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sid_envelope_if bus ();

  sid_envelope #(
    .RATE_W (15),
    .EXP_W  (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int PER [16] = '{9, 32, 63, 95, 149, 220, 267, 313,
                              392, 977, 1954, 3126, 3907, 11720, 19532, 31251};

  int         m_rc, m_ec, m_ep, m_env;
  bit         m_hold, m_gq;
  env_state_e m_state;

  function automatic int exp_table(input int e, input int cur);
    if (e == 255) return 1;
    if (e == 93)  return 2;
    if (e == 54)  return 4;
    if (e == 26)  return 8;
    if (e == 14)  return 16;
    if (e == 6)   return 30;
    if (e == 0)   return 1;
    return cur;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, applied with the inputs present at that edge.
  task automatic model_edge();
    int  per, old_env;
    bit  step, estep;
    if (!rst_n) begin
      m_rc = 0; m_ec = 0; m_ep = 1; m_env = 0;
      m_hold = 1; m_gq = 0; m_state = RELEASE;
    end else if (bus.tick) begin
      if (m_state == ATTACK)             per = PER[bus.regs.attack];
      else if (m_state == DECAY_SUSTAIN) per = PER[bus.regs.decay];
      else                               per = PER[bus.regs.release_];
`ifdef SID_ENV_ADSR_BUG_EN
      step = (m_rc == per - 1);
`else
      step = (m_rc >= per - 1);
`endif
      m_rc    = step ? 0 : (m_rc + 1) % 32768;
      old_env = m_env;
      estep   = 0;
      if (step) begin
        if (m_state == ATTACK) begin
          m_ec  = 0;
          m_env = (m_env < 255) ? m_env + 1 : 255;
          if (m_env == 255) m_state = DECAY_SUSTAIN;
        end else begin
          m_ec = (m_ec + 1) % 32;
          if (m_ec == m_ep) begin
            m_ec  = 0;
            estep = 1;
          end
        end
      end
      if (estep && m_env > 0) begin
        if (m_state == DECAY_SUSTAIN && m_env != 17 * int'(bus.regs.sustain)) m_env--;
        else if (m_state == RELEASE && !m_hold) m_env--;
      end
      if (m_env != old_env) begin
        m_ep = exp_table(m_env, m_ep);
        if (m_env == 0) m_hold = 1;
      end
      if (bus.regs.gate && !m_gq) begin
        m_state = ATTACK;
        m_hold  = 0;
      end else if (!bus.regs.gate && m_gq) begin
        m_state = RELEASE;
      end
      m_gq = bus.regs.gate;
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("env", 32'(bus.env), 32'(m_env));
    check("state", 32'(bus.state), 32'(m_state));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_cycle();
    clk_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, first, t, last_t, prev_env, extreme;
    rst_n    = 1'b0;
    bus.tick = 1'b0;
    bus.regs = '0;

    // Reset state
    do_reset();
    check("reset_env", 32'(bus.env), 32'd0);
    check("reset_state", 32'(bus.state), 32'(RELEASE));
    check("reset_rate_cnt", 32'(dut.u_rate.rate_cnt_reg), 32'd0);
    check("reset_exp_cnt", 32'(dut.exp_cnt_reg), 32'd0);
    check("reset_hold_zero", 32'(dut.hold_zero_reg), 32'd1);
    $display("step reset: env=%0d state=%0d", bus.env, bus.state);

    // Zero hold with gate low
    bus.tick = 1'b1;
    extreme  = 0;
    for (int i = 0; i < 10000; i++) begin
      clk_cycle();
      if (int'(bus.env) > extreme) extreme = int'(bus.env);
    end
    check("zero_hold_max_env", 32'(extreme), 32'd0);
    $display("step zero_hold: max env=%0d over 10000 ticks", extreme);

    // Attack ramp from a freshly reset rate counter
    do_reset();
    bus.regs.attack   = 4'd0;
    bus.regs.decay    = 4'd0;
    bus.regs.sustain  = 4'hA;
    bus.regs.release_ = 4'd0;
    bus.regs.gate     = 1'b1;
    cnt = 0; first = 0;
    while (bus.env !== 8'hFF && cnt < 3000) begin
      clk_cycle();
      cnt++;
      if (bus.env == 8'h01 && first == 0) first = cnt;
    end
    check("attack_first_step", 32'(first), 32'd9);
    check("attack_ticks", 32'(cnt), 32'd2295);
    check("attack_end_state", 32'(bus.state), 32'(DECAY_SUSTAIN));
    $display("step attack: first=%0d full=%0d ticks", first, cnt);

    // Decay to sustain AA and hold there
    cnt = 0;
    while (bus.env !== 8'hAA && cnt < 2000) begin
      clk_cycle();
      cnt++;
    end
    check("decay_ticks", 32'(cnt), 32'd765);
    extreme = 255;
    for (int i = 0; i < 2000; i++) begin
      clk_cycle();
      if (int'(bus.env) < extreme) extreme = int'(bus.env);
    end
    check("sustain_min_env", 32'(extreme), 32'hAA);
    $display("step decay: reached AA after %0d ticks, min=%0h", cnt, extreme);

    // Release to zero, checking the doubled spacing between 5D and 36
    bus.regs.gate = 1'b0;
    t = 0; last_t = 0; prev_env = int'(bus.env);
    while (bus.env !== 8'h00 && t < 8000) begin
      clk_cycle();
      t++;
      if (int'(bus.env) != prev_env) begin
        if (bus.env >= 8'h36 && bus.env <= 8'h5C) check("release_spacing", 32'(t - last_t), 32'd18);
        last_t   = t;
        prev_env = int'(bus.env);
      end
    end
    check("release_reached_zero", 32'(bus.env), 32'd0);
    check("release_hold_zero", 32'(dut.hold_zero_reg), 32'd1);
    extreme = 0;
    for (int i = 0; i < 20000; i++) begin
      clk_cycle();
      if (int'(bus.env) > extreme) extreme = int'(bus.env);
    end
    check("freeze_max_env", 32'(extreme), 32'd0);
    $display("step release: zero after %0d ticks, frozen max=%0d", t, extreme);

    // Reset in the middle of an attack
    do_reset();
    bus.regs.gate = 1'b1;
    cnt = 0;
    while (bus.env !== 8'h40 && cnt < 1000) begin
      clk_cycle();
      cnt++;
    end
    check("mid_attack_env", 32'(bus.env), 32'h40);
    rst_n = 1'b0;
    clk_cycle();
    rst_n = 1'b1;
    check("mid_reset_env", 32'(bus.env), 32'd0);
    check("mid_reset_state", 32'(bus.state), 32'(RELEASE));
    check("mid_reset_rate_cnt", 32'(dut.u_rate.rate_cnt_reg), 32'd0);
    check("mid_reset_exp_cnt", 32'(dut.exp_cnt_reg), 32'd0);
    $display("step mid_reset: env=%0d state=%0d", bus.env, bus.state);

    // Lowering the rate period below the running count
    do_reset();
    bus.regs.attack   = 4'd10;
    bus.regs.release_ = 4'd10;
    bus.regs.gate     = 1'b1;
    for (int i = 0; i < 1000; i++) clk_cycle();
    check("period_drop_rate_cnt", 32'(dut.u_rate.rate_cnt_reg), 32'd1000);
    check("period_drop_env_before", 32'(bus.env), 32'd0);
    bus.regs.attack = 4'd0;
    cnt = 0;
    while (bus.env !== 8'h01 && cnt < 40000) begin
      clk_cycle();
      cnt++;
    end
`ifdef SID_ENV_ADSR_BUG_EN
    // Counter climbs from 1000 through the wrap to 8; the step tick is included.
    check("period_drop_ticks", 32'(cnt), 32'(32768 - 1000 + 8 + 1));
`else
    check("period_drop_ticks", 32'(cnt), 32'd1);
`endif
    $display("step period_drop: first step after %0d ticks", cnt);

    // Randomized gate, register and tick activity against the model
    bus.regs.release_ = 4'd0;
    for (int i = 0; i < 4000; i++) begin
      bus.tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        bus.regs.gate     = 1'($urandom_range(0, 1));
        bus.regs.attack   = 4'($urandom_range(0, 2));
        bus.regs.decay    = 4'($urandom_range(0, 2));
        bus.regs.sustain  = 4'($urandom_range(0, 15));
        bus.regs.release_ = 4'($urandom_range(0, 2));
      end
      rst_n = ($urandom_range(0, 1999) != 0);
      clk_cycle();
    end
    rst_n = 1'b1;
    $display("step random: 4000 cycles, final env=%0d state=%0d", bus.env, bus.state);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
